// File: rtl/fp_mat_pkg.sv
// Shared constants and FSM state type for the 8.8 fixed-point matrix operand loader.
package fp_mat_pkg;

  localparam int ELEM_W = 16;
  localparam int FRAC_W = 8;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    FULL   = 2'd2
  } state_t;

endpackage

// File: rtl/fp_mat_bank.sv
// One operand bank: per-element write-enable decode over a flat register array,
// with a whole-bank parallel load used to transfer a complete bank in one edge.
module fp_mat_bank
  import fp_mat_pkg::*;
#(
  parameter int DATA_WIDTH = ELEM_W,
  parameter int N          = 16,
  parameter int IW         = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [IW-1:0]         wr_idx_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  cp_en_i,
  input  logic [N*DATA_WIDTH-1:0] cp_data_i,
  output logic [N*DATA_WIDTH-1:0] data_o
);

  for (genvar k = 0; k < N; k++) begin : g_elem
    logic                  we;
    logic [DATA_WIDTH-1:0] elem_q;

    assign we = wr_en_i && (wr_idx_i == IW'(k));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       elem_q <= '0;
      else if (cp_en_i) elem_q <= cp_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      else if (we)      elem_q <= wr_data_i;
    end

    assign data_o[k*DATA_WIDTH +: DATA_WIDTH] = elem_q;
  end

endmodule

// File: rtl/fp_mat_loader.sv
// Streams NA+NB fixed-point elements into flat A/B operand buses for a matmul.
// Optional shadow bank (double buffering) enabled by `define FP_MAT_LOADER_DBUF_EN.
module fp_mat_loader
  import fp_mat_pkg::*;
#(
  parameter int DATA_WIDTH = ELEM_W,
  parameter int ROW_1      = 4,
  parameter int COL_1      = 4,
  parameter int COL_2      = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_last,
  output logic                              in_ready,
  output logic [DATA_WIDTH*ROW_1*COL_1-1:0] out_a,
  output logic [DATA_WIDTH*COL_1*COL_2-1:0] out_b,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              err_last
);

  localparam int NA   = ROW_1 * COL_1;
  localparam int NB   = COL_1 * COL_2;
  localparam int NMAX = (NA > NB) ? NA : NB;
  localparam int CW   = (NMAX > 1) ? $clog2(NMAX) : 1;
  localparam logic [CW-1:0] LAST_A = CW'(NA - 1);
  localparam logic [CW-1:0] LAST_B = CW'(NB - 1);

  state_t                   state_q, state_d, fill_ph;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     err_q, err_d;
  logic                     accept, hs, done_a, done_b, a_we, b_we, cp_en;
  logic [DATA_WIDTH*NA-1:0] cp_a;
  logic [DATA_WIDTH*NB-1:0] cp_b;

  assign accept    = in_valid && in_ready;
  assign hs        = (state_q == FULL) && out_ready;
  assign out_valid = (state_q == FULL);
  assign err_last  = err_q;
  // fill_ph is the phase of whichever bank is currently taking input
  assign done_a    = accept && (fill_ph == LOAD_A) && (cnt_q == LAST_A);
  assign done_b    = accept && (fill_ph == LOAD_B) && (cnt_q == LAST_B);
  assign a_we      = accept && (state_q == LOAD_A);
  assign b_we      = accept && (state_q == LOAD_B);

`ifdef FP_MAT_LOADER_DBUF_EN
  state_t                   sh_q, sh_d;
  logic                     sa_we, sb_we;
  logic [DATA_WIDTH*NA-1:0] sh_a;
  logic [DATA_WIDTH*NB-1:0] sh_b;

  assign fill_ph  = (state_q == FULL) ? sh_q : state_q;
  assign in_ready = rst_n && !((state_q == FULL) && (sh_q == FULL));
  assign sa_we    = accept && (state_q == FULL) && (sh_q == LOAD_A);
  assign sb_we    = accept && (state_q == FULL) && (sh_q == LOAD_B);
  assign cp_en    = hs;

  // Forward the element landing this edge so a same-edge completion is not lost
  always_comb begin
    cp_a = sh_a;
    cp_b = sh_b;
    if (sa_we) cp_a[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH] = in_data;
    if (sb_we) cp_b[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH] = in_data;
  end

  fp_mat_bank #(.DATA_WIDTH(DATA_WIDTH), .N(NA), .IW(CW)) u_sh_a (
    .clk(clk), .rst_n(rst_n), .wr_en_i(sa_we), .wr_idx_i(cnt_q), .wr_data_i(in_data),
    .cp_en_i(1'b0), .cp_data_i('0), .data_o(sh_a)
  );

  fp_mat_bank #(.DATA_WIDTH(DATA_WIDTH), .N(NB), .IW(CW)) u_sh_b (
    .clk(clk), .rst_n(rst_n), .wr_en_i(sb_we), .wr_idx_i(cnt_q), .wr_data_i(in_data),
    .cp_en_i(1'b0), .cp_data_i('0), .data_o(sh_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh_q <= LOAD_A;
    else        sh_q <= sh_d;
  end
`else
  assign fill_ph  = state_q;
  assign in_ready = rst_n && (state_q != FULL);
  assign cp_en    = 1'b0;
  assign cp_a     = '0;
  assign cp_b     = '0;
`endif

  fp_mat_bank #(.DATA_WIDTH(DATA_WIDTH), .N(NA), .IW(CW)) u_bank_a (
    .clk(clk), .rst_n(rst_n), .wr_en_i(a_we), .wr_idx_i(cnt_q), .wr_data_i(in_data),
    .cp_en_i(cp_en), .cp_data_i(cp_a), .data_o(out_a)
  );

  fp_mat_bank #(.DATA_WIDTH(DATA_WIDTH), .N(NB), .IW(CW)) u_bank_b (
    .clk(clk), .rst_n(rst_n), .wr_en_i(b_we), .wr_idx_i(cnt_q), .wr_data_i(in_data),
    .cp_en_i(cp_en), .cp_data_i(cp_b), .data_o(out_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_A;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
`ifdef FP_MAT_LOADER_DBUF_EN
    sh_d    = sh_q;
`endif
    if (accept) begin
      cnt_d = cnt_q + CW'(1);
      // Framing errors are only flagged; counting alone defines the pair boundary
      if (in_last != done_b) err_d = 1'b1;
    end
    if (done_a || done_b) cnt_d = '0;
    unique case (state_q)
      LOAD_A: if (done_a) state_d = LOAD_B;
      LOAD_B: if (done_b) state_d = FULL;
      FULL: begin
`ifdef FP_MAT_LOADER_DBUF_EN
        if (done_a)      sh_d = LOAD_B;
        else if (done_b) sh_d = FULL;
        if (hs) begin
          sh_d = LOAD_A;
          // A partial shadow moves to the output bank and filling resumes there
          if (!((sh_q == FULL) || done_b)) state_d = done_a ? LOAD_B : sh_q;
        end
`else
        if (hs) state_d = LOAD_A;
`endif
      end
      default: state_d = LOAD_A;
    endcase
  end

endmodule

// File: tb/tb_fp_mat_loader.sv
// Scoreboard bench for fp_mat_loader: expected pairs queued at the final accept, checked at handshake.
module tb_fp_mat_loader;

  typedef struct packed {
    logic [255:0] a;
    logic [127:0] b;
    logic         err;
  } exp_t;

`ifdef FP_MAT_LOADER_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_last, in_ready, out_valid, out_ready, err_last;
  logic [15:0]  in_data;
  logic [255:0] out_a;
  logic [127:0] out_b;

  int           n_vec = 0;
  int           n_err = 0;
  exp_t         sb[$];
  logic [15:0]  elems[24];
  bit           lastm[24];
  bit           err_model = 1'b0;
  exp_t         last_exp;

  fp_mat_loader dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_a(out_a), .out_b(out_b), .out_valid(out_valid),
    .out_ready(out_ready), .err_last(err_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic set_std();
    for (int i = 0; i < 24; i++) begin
      elems[i] = (i < 16) ? 16'((i + 1) * 256) : 16'h0080;
      lastm[i] = (i == 23);
    end
  endtask

  task automatic set_rand();
    for (int i = 0; i < 24; i++) begin
      elems[i] = 16'($urandom);
      lastm[i] = (i == 23);
    end
  endtask

  task automatic send_elem(input logic [15:0] d, input bit last, input bit rnd);
    int t;
    if (rnd) begin
      while ($urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        sync();
      end
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    t = 0;
    @(negedge clk);
    while (!in_ready) begin
      t++;
      if (t > 200) begin
        chk("ready_timeout", 0, 1);
        break;
      end
      @(negedge clk);
    end
    sync();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic load_pair(input bit rnd, input bit tchk);
    exp_t e;
    for (int i = 0; i < 24; i++) begin
      if (tchk && i == 23) chk("valid_early", out_valid, 0);
      send_elem(elems[i], lastm[i], rnd);
      if (lastm[i] != (i == 23)) err_model = 1'b1;
      chk("err_last", err_last, err_model);
    end
    e = '0;
    for (int k = 0; k < 16; k++) e.a[k*16 +: 16] = elems[k];
    for (int k = 0; k < 8; k++)  e.b[k*16 +: 16] = elems[16 + k];
    e.err = err_model;
    sb.push_back(e);
    last_exp = e;
    if (tchk) begin
      @(negedge clk);
      chk("valid_rise", out_valid, 1);
    end
  endtask

  task automatic drain();
    int t;
    out_ready = 1'b1;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() != 0) chk("drain", sb.size(), 0);
    sync();
    sync();
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_pair", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pair_a", out_a, e.a);
        chk("pair_b", out_b, e.b);
        chk("pair_err", err_last, e.err);
      end
    end
  end

  initial begin
    exp_t p1, p2;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err_last, 0);
    chk("rst_out_a", out_a, 0);
    chk("rst_out_b", out_b, 0);
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);
    sync();

    // back-to-back reference load
    set_std();
    load_pair(1'b0, 1'b1);
    chk("a_elem0", out_a[15:0], 16'h0100);
    chk("b_elem7", out_b[127:112], 16'h0080);

    // consumer stall: buses frozen, handshake returns to loading
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, DBUF ? 1 : 0);
      chk("hold_a", out_a, last_exp.a);
      chk("hold_b", out_b, last_exp.b);
    end
    sync();
    out_ready = 1'b1;
    sync();
    out_ready = 1'b0;
    @(negedge clk);
    chk("post_hs_valid", out_valid, 0);
    chk("post_hs_ready", in_ready, 1);
    sync();

    // random in_valid gaps with out_ready held high throughout
    out_ready = 1'b1;
    load_pair(1'b1, 1'b1);
    sync();
    set_rand();
    load_pair(1'b1, 1'b0);
    drain();

    // framing error on element 10
    set_std();
    lastm[9] = 1'b1;
    load_pair(1'b0, 1'b1);
    drain();
    chk("err_sticky", err_last, 1);

    // reset mid-load after 7 elements
    out_ready = 1'b0;
    set_rand();
    for (int i = 0; i < 7; i++) send_elem(elems[i], 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    err_model = 1'b0;
    chk("mid_rst_a", out_a, 0);
    chk("mid_rst_b", out_b, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_err", err_last, 0);
    chk("mid_rst_ready", in_ready, 0);
    sync();
    rst_n = 1'b1;
    set_rand();
    load_pair(1'b0, 1'b1);
    drain();

    if (DBUF) begin
      out_ready = 1'b0;
      sync();
      set_rand();
      load_pair(1'b0, 1'b0);
      p1 = last_exp;
      set_rand();
      load_pair(1'b0, 1'b0);
      p2 = last_exp;
      @(negedge clk);
      chk("dbuf_ready_low", in_ready, 0);
      chk("dbuf_a_first", out_a, p1.a);
      sync();
      out_ready = 1'b1;
      sync();
      out_ready = 1'b0;
      @(negedge clk);
      chk("dbuf_valid", out_valid, 1);
      chk("dbuf_a_second", out_a, p2.a);
      chk("dbuf_b_second", out_b, p2.b);
      chk("dbuf_ready_back", in_ready, 1);
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fp_mat_loader.md
FP_MAT_LOADER -- requirements
Module: fp_mat_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of one 8.8 fixed-point element.
REQ-002 SHALL have parameter ROW_1, default 4, rows of matrix A.
REQ-003 SHALL have parameter COL_1, default 4, columns of A; this is also the rows of B.
REQ-004 SHALL have parameter COL_2, default 2, columns of B.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1 bit: an input element is offered.
REQ-008 SHALL have port in_data, input, DATA_WIDTH bits: the element value.
REQ-009 SHALL have port in_last, input, 1 bit: the producer marks the final element of a pair.
REQ-010 SHALL have port in_ready, output, 1 bit: the loader accepts an element.
REQ-011 SHALL have port out_a, output, DATA_WIDTH*ROW_1*COL_1 bits: flat A, feeding the matmul in_1.
REQ-012 SHALL have port out_b, output, DATA_WIDTH*COL_1*COL_2 bits: flat B, feeding the matmul in_2.
REQ-013 SHALL have port out_valid, output, 1 bit: a complete operand pair is held.
REQ-014 SHALL have port out_ready, input, 1 bit: the consumer has taken the pair.
REQ-015 SHALL have port err_last, output, 1 bit: sticky in_last framing error.

Function
REQ-016 An element SHALL transfer on a rising clk when in_valid and in_ready are both 1.
REQ-017 The first NA = ROW_1*COL_1 accepted elements SHALL fill A, row-major; the next NB = COL_1*COL_2 SHALL fill B, row-major.
REQ-018 Element k of a matrix SHALL occupy bits [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k] of its flat bus.
REQ-019 The FSM SHALL have states LOAD_A, LOAD_B and FULL.
REQ-020 LOAD_A SHALL go to LOAD_B on accepting element NA-1; LOAD_B SHALL go to FULL on accepting element NB-1.
REQ-021 FULL SHALL go to LOAD_A on a cycle with out_valid and out_ready both 1.
REQ-022 in_ready SHALL be 1 in LOAD_A and LOAD_B and 0 in FULL (without the REQ-034 feature).
REQ-023 out_valid SHALL be 1 exactly in FULL, one cycle after the last B element is accepted.
REQ-024 out_a and out_b SHALL stay stable while out_valid is 1.
REQ-025 A single element counter, clog2(max(NA,NB)) bits, SHALL clear on each matrix boundary.
REQ-026 err_last SHALL set if in_last is 1 on any accepted element except the last B element, or 0 on that last B element.
REQ-027 A framing error SHALL NOT alter counting: the pair still completes after exactly NA+NB elements.
REQ-028 out_ready asserted while out_valid is 0 SHALL be ignored.
REQ-029 No arithmetic SHALL be performed on element data; bits pass through unchanged.

Reset
REQ-030 On rst_n low, at any time, the FSM SHALL enter LOAD_A, the counter SHALL be 0, and out_valid and err_last SHALL be 0.
REQ-031 On rst_n low, out_a and out_b SHALL be all zeros.
REQ-032 On rst_n low, in_ready SHALL be 0 while reset is held and 1 in the first cycle after release.
REQ-033 Reset mid-load SHALL discard the partial pair.

Configuration
REQ-034 Macro FP_MAT_LOADER_DBUF_EN SHALL add a shadow A/B bank.
- With it: in FULL, in_ready stays 1 and input fills the shadow bank through the same LOAD_A/LOAD_B counting.
- On the out handshake, a complete shadow bank SHALL be copied to the output bank the same edge, and FULL is held.
- A pair completing on the same edge as the handshake SHALL be copied directly.
- in_ready SHALL drop only while the shadow bank is complete and unconsumed.
REQ-035 Without FP_MAT_LOADER_DBUF_EN the design SHALL contain no shadow storage and SHALL behave per REQ-022.

Structure
REQ-036 A shared package fp_mat_pkg SHALL hold:
- the element width constant (16);
- the fractional-bit constant (8);
- the FSM state typedef (LOAD_A, LOAD_B, FULL).
REQ-037 The bank, write-enable decode plus the flat register array, SHALL be one sub-module, fp_mat_bank, instanced per bank.

Verification
REQ-038 Stream A = 0x0100..0x1000 (1.0..16.0) and B = 0x0080 x8, in_last on the 24th element -> out_valid rises one cycle later; out_a[15:0] = 0x0100 and out_b[127:112] = 0x0080.
REQ-039 Hold out_ready 0 for 5 cycles in FULL -> in_ready = 0 and the buses are unchanged; the handshake returns the FSM to LOAD_A.
REQ-040 in_last on element 10 -> err_last = 1 and sticky; out_valid still rises after element 24.
REQ-041 Pulse rst_n low after 7 elements -> all outputs are zero; a fresh 24-element load completes correctly.
REQ-042 Toggle in_valid randomly, 50 % -> the result is identical to the back-to-back load of REQ-038.
REQ-043 With FP_MAT_LOADER_DBUF_EN, load two pairs back-to-back while out_ready = 0, then pulse it -> the second pair appears the cycle after the handshake; in_ready is 0 only after element 48.
